// File: rtl/escalonador_andares.sv
// SCAN request scheduler for the elevator core: latches floor calls, picks the next target
// and sequences the door dwell. Define CAPACIDADE_EN to enable overload hold of the door.
module escalonador_andares #(
  parameter int unsigned NUM_ANDARES  = 5,
  parameter int unsigned PORTA_CICLOS = 3,
  parameter int unsigned CAPACIDADE   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_ANDARES-1:0] req,
  input  logic [2:0]             andar_atual,
  input  logic                   parado,
  input  logic [3:0]             num_people,
  output logic [2:0]             andar_requisitado,
  output logic                   alvo_valido,
  output logic [NUM_ANDARES-1:0] pendentes,
  output logic                   porta_aberta,
  output logic                   direcao_sobe,
  output logic                   sobrecarga
);

  localparam int unsigned CntW = (PORTA_CICLOS > 1) ? $clog2(PORTA_CICLOS) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(PORTA_CICLOS - 1);

  typedef enum logic [1:0] {StIdle, StSelect, StMoving, StPorta} state_e;

  state_e                 state_q, state_d;
  logic [NUM_ANDARES-1:0] pend_q, pend_d, req_prev_q;
  logic [2:0]             alvo_q, alvo_d;
  logic                   valido_q, valido_d;
  logic                   porta_q, porta_d;
  logic                   dir_q, dir_d;
  logic                   sobre_q, sobre_d;
  logic [CntW-1:0]        cnt_q, cnt_d;

  logic [NUM_ANDARES-1:0] rise, match_vec, tgt_vec, above_vec, below_vec, set_vec, clr_vec;
  logic                   here_call, here_pend, any_above, any_below, arrive;
  logic [2:0]             lo_above, hi_below;

  // Out-of-range andar_atual simply matches no bit; above/below stay numeric.
  always_comb begin
    match_vec = '0;
    tgt_vec   = '0;
    above_vec = '0;
    below_vec = '0;
    for (int unsigned i = 0; i < NUM_ANDARES; i++) begin
      match_vec[i] = (3'(i) == andar_atual);
      tgt_vec[i]   = (3'(i) == alvo_q);
      above_vec[i] = (3'(i) > andar_atual);
      below_vec[i] = (3'(i) < andar_atual);
    end
  end

  always_comb begin
    lo_above = '0;
    hi_below = '0;
    for (int i = int'(NUM_ANDARES) - 1; i >= 0; i--) begin
      if (pend_q[i] && above_vec[i]) lo_above = 3'(i);
    end
    for (int i = 0; i < int'(NUM_ANDARES); i++) begin
      if (pend_q[i] && below_vec[i]) hi_below = 3'(i);
    end
  end

  assign rise      = req & ~req_prev_q;
  assign here_call = parado && ((state_q == StIdle) || (state_q == StPorta)) &&
                     (|(rise & match_vec));
  assign here_pend = |(pend_q & match_vec);
  assign any_above = |(pend_q & above_vec);
  assign any_below = |(pend_q & below_vec);
  assign arrive    = parado && (andar_atual == alvo_q);

  // Pending set: a call at the current stopped floor is served by the door, not latched.
  always_comb begin
    set_vec = here_call ? (rise & ~match_vec) : rise;
    clr_vec = '0;
    if (state_q == StSelect && here_pend) clr_vec = match_vec;
    if (state_q == StMoving && arrive)    clr_vec = tgt_vec;
    pend_d = (pend_q | set_vec) & ~clr_vec;
  end

`ifdef CAPACIDADE_EN
  assign sobre_d = (32'(num_people) > CAPACIDADE);
`else
  logic unused_num_people;
  assign unused_num_people = ^num_people;
  assign sobre_d = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      pend_q     <= '0;
      req_prev_q <= '0;
      alvo_q     <= '0;
      valido_q   <= 1'b0;
      porta_q    <= 1'b0;
      dir_q      <= 1'b1;
      sobre_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      req_prev_q <= req;
      alvo_q     <= alvo_d;
      valido_q   <= valido_d;
      porta_q    <= porta_d;
      dir_q      <= dir_d;
      sobre_q    <= sobre_d;
      cnt_q      <= cnt_d;
    end
  end

  // IDLE looks at pend_d so a fresh call reaches SELECT on the edge that latches it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (here_call)                          state_d = StPorta;
        else if ((pend_d != '0) && !sobre_q)    state_d = StSelect;
      end
      StSelect: begin
        if (here_pend)                          state_d = StPorta;
        else if (any_above || any_below)        state_d = StMoving;
        else                                    state_d = StIdle;
      end
      StMoving: begin
        if (arrive)                             state_d = StPorta;
      end
      StPorta: begin
        if (!here_call && !sobre_q && (cnt_q == '0)) state_d = StSelect;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    alvo_d   = alvo_q;
    valido_d = valido_q;
    porta_d  = porta_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (here_call) begin
          porta_d = 1'b1;
          cnt_d   = CntLoad;
        end
      end
      StSelect: begin
        if (here_pend) begin
          porta_d = 1'b1;
          cnt_d   = CntLoad;
        end else if (dir_q && any_above) begin
          alvo_d   = lo_above;
          valido_d = 1'b1;
        end else if (any_below) begin
          alvo_d   = hi_below;
          valido_d = 1'b1;
          dir_d    = 1'b0;
        end else if (any_above) begin
          alvo_d   = lo_above;
          valido_d = 1'b1;
          dir_d    = 1'b1;
        end
      end
      StMoving: begin
        if (arrive) begin
          valido_d = 1'b0;
          porta_d  = 1'b1;
          cnt_d    = CntLoad;
        end
      end
      StPorta: begin
        if (here_call || sobre_q) cnt_d = CntLoad;
        else if (cnt_q == '0)     porta_d = 1'b0;
        else                      cnt_d = cnt_q - CntW'(1);
      end
      default: ;
    endcase
  end

  assign andar_requisitado = alvo_q;
  assign alvo_valido       = valido_q;
  assign pendentes         = pend_q;
  assign porta_aberta      = porta_q;
  assign direcao_sobe      = dir_q;
  assign sobrecarga        = sobre_q;

endmodule

// File: tb/tb_escalonador_andares.sv
// Directed self-checking bench for escalonador_andares (5 floors, 3-cycle dwell).
module tb_escalonador_andares;

  logic       clk;
  logic       reset;
  logic [4:0] req;
  logic [2:0] andar_atual;
  logic       parado;
  logic [3:0] num_people;
  logic [2:0] andar_requisitado;
  logic       alvo_valido;
  logic [4:0] pendentes;
  logic       porta_aberta;
  logic       direcao_sobe;
  logic       sobrecarga;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  escalonador_andares #(
    .NUM_ANDARES (5),
    .PORTA_CICLOS(3),
    .CAPACIDADE  (8)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .req              (req),
    .andar_atual      (andar_atual),
    .parado           (parado),
    .num_people       (num_people),
    .andar_requisitado(andar_requisitado),
    .alvo_valido      (alvo_valido),
    .pendentes        (pendentes),
    .porta_aberta     (porta_aberta),
    .direcao_sobe     (direcao_sobe),
    .sobrecarga       (sobrecarga)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".pend"}, 32'(pendentes), 32'h0);
    check({tag, ".alvo"}, 32'(andar_requisitado), 32'h0);
    check({tag, ".valido"}, 32'(alvo_valido), 32'h0);
    check({tag, ".porta"}, 32'(porta_aberta), 32'h0);
    check({tag, ".dir"}, 32'(direcao_sobe), 32'h1);
    check({tag, ".sobre"}, 32'(sobrecarga), 32'h0);
  endtask

  task automatic do_reset();
    #1 reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset       = 1'b0;
    req         = '0;
    andar_atual = 3'd0;
    parado      = 1'b1;
    num_people  = 4'd0;
    tick();
    tick();
    check_reset_vals("rst_held");
    reset = 1'b1;
    tick();
    check_reset_vals("rst_rel");

    // Call at floor 3 from IDLE at floor 0: latch, then target one edge later.
    req = 5'b01000;
    tick();
    check("t1.pend", 32'(pendentes), 32'h08);
    check("t1.valido_early", 32'(alvo_valido), 32'h0);
    req = '0;
    tick();
    check("t1.valido", 32'(alvo_valido), 32'h1);
    check("t1.alvo", 32'(andar_requisitado), 32'h3);
    check("t1.dir", 32'(direcao_sobe), 32'h1);
    parado = 1'b0;
    tick();
    andar_atual = 3'd3;
    parado      = 1'b1;
    tick();
    check("t1.arr_porta", 32'(porta_aberta), 32'h1);
    check("t1.arr_pend", 32'(pendentes), 32'h0);
    check("t1.arr_valido", 32'(alvo_valido), 32'h0);
    tick();
    tick();
    check("t1.dwell3", 32'(porta_aberta), 32'h1);
    tick();
    check("t1.dwell_end", 32'(porta_aberta), 32'h0);

    // SCAN: moving 2->4, calls at 1 and 3 arrive mid-move.
    do_reset();
    andar_atual = 3'd2;
    parado      = 1'b1;
    req         = 5'b10000;
    tick();
    req = '0;
    tick();
    check("t2.alvo4", 32'(andar_requisitado), 32'h4);
    parado = 1'b0;
    req    = 5'b01010;
    tick();
    check("t2.pend", 32'(pendentes), 32'h1a);
    check("t2.frozen_a", 32'(andar_requisitado), 32'h4);
    andar_atual = 3'd3;
    tick();
    check("t2.frozen_b", 32'(andar_requisitado), 32'h4);
    andar_atual = 3'd4;
    parado      = 1'b1;
    tick();
    check("t2.arr_porta", 32'(porta_aberta), 32'h1);
    check("t2.arr_pend", 32'(pendentes), 32'h0a);
    tick();
    tick();
    check("t2.dwell3", 32'(porta_aberta), 32'h1);
    tick();
    check("t2.dwell_end", 32'(porta_aberta), 32'h0);
    tick();
    check("t2.rev_alvo", 32'(andar_requisitado), 32'h3);
    check("t2.rev_dir", 32'(direcao_sobe), 32'h0);
    check("t2.rev_valido", 32'(alvo_valido), 32'h1);
    parado = 1'b0;
    tick();
    andar_atual = 3'd3;
    parado      = 1'b1;
    tick();
    check("t2.arr3_pend", 32'(pendentes), 32'h02);
    repeat (4) tick();
    check("t2.next_alvo", 32'(andar_requisitado), 32'h1);
    check("t2.next_dir", 32'(direcao_sobe), 32'h0);
    req = '0;

    // Going up from 2 with calls at 0 and 4: continue up first.
    do_reset();
    andar_atual = 3'd2;
    parado      = 1'b1;
    req         = 5'b10001;
    tick();
    req = '0;
    tick();
    check("t3.alvo", 32'(andar_requisitado), 32'h4);
    check("t3.dir", 32'(direcao_sobe), 32'h1);

    // Call at the current stopped floor opens the door; a re-press restarts the dwell.
    do_reset();
    andar_atual = 3'd1;
    parado      = 1'b1;
    req         = 5'b00010;
    tick();
    check("t4.pend", 32'(pendentes), 32'h0);
    check("t4.porta", 32'(porta_aberta), 32'h1);
    req = '0;
    tick();
    req = 5'b00010;
    tick();
    check("t4.pend_re", 32'(pendentes), 32'h0);
    req = '0;
    tick();
    tick();
    check("t4.restart", 32'(porta_aberta), 32'h1);
    tick();
    check("t4.end", 32'(porta_aberta), 32'h0);

    // Asynchronous reset while moving, then held switches latch once each.
    do_reset();
    andar_atual = 3'd0;
    parado      = 1'b1;
    req         = 5'b10110;
    tick();
    check("t5.pend", 32'(pendentes), 32'h16);
    tick();
    check("t5.moving", 32'(alvo_valido), 32'h1);
    parado = 1'b0;
    tick();
    #2 reset = 1'b0;
    #1 check_reset_vals("t5.async");
    tick();
    reset = 1'b1;
    tick();
    check("t5.relatch", 32'(pendentes), 32'h16);

    // Floor index beyond the last floor: nothing matches, call at 0 lies below.
    do_reset();
    req         = '0;
    andar_atual = 3'd7;
    parado      = 1'b1;
    req         = 5'b00001;
    tick();
    req = '0;
    check("t7.pend", 32'(pendentes), 32'h01);
    tick();
    check("t7.alvo", 32'(andar_requisitado), 32'h0);
    check("t7.valido", 32'(alvo_valido), 32'h1);
    check("t7.dir", 32'(direcao_sobe), 32'h0);

`ifdef CAPACIDADE_EN
    // Overload holds the door open until the count drops to capacity.
    do_reset();
    andar_atual = 3'd2;
    parado      = 1'b1;
    num_people  = 4'd9;
    req         = 5'b00100;
    tick();
    check("t6.sobre", 32'(sobrecarga), 32'h1);
    check("t6.porta", 32'(porta_aberta), 32'h1);
    req = 5'b10000;
    repeat (6) tick();
    check("t6.held", 32'(porta_aberta), 32'h1);
    check("t6.pend", 32'(pendentes), 32'h10);
    num_people = 4'd8;
    tick();
    check("t6.clear", 32'(sobrecarga), 32'h0);
    tick();
    tick();
    check("t6.still_open", 32'(porta_aberta), 32'h1);
    tick();
    check("t6.closed", 32'(porta_aberta), 32'h0);
    tick();
    check("t6.alvo", 32'(andar_requisitado), 32'h4);
    check("t6.valido", 32'(alvo_valido), 32'h1);
`else
    num_people = 4'd15;
    tick();
    tick();
    check("t6.no_sobre", 32'(sobrecarga), 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
